// File: rtl/raster_frame_sched_if.sv
// raster_frame_sched_if: assembled-triangle output stream with valid/ready handshake
interface raster_frame_sched_if #(
  parameter int VTX_W   = 108,
  parameter int TRANS_W = 384,
  parameter int IW      = 8
);
  logic               tri_valid;
  logic               tri_ready;
  logic [VTX_W-1:0]   v0, v1, v2;
  logic [TRANS_W-1:0] tri_transform;
  logic [IW-1:0]      tri_inst;
  modport master (output tri_valid, v0, v1, v2, tri_transform, tri_inst, input tri_ready);
  modport slave  (input tri_valid, v0, v1, v2, tri_transform, tri_inst, output tri_ready);
endinterface

// File: rtl/raster_frame_sched.sv
// raster_frame_sched: per-frame instance/triangle/vertex read sequencer feeding the transform stage
module raster_frame_sched #(
  parameter int MAX_INST = 256,
  parameter int MAX_VERT = 8192,
  parameter int MAX_TRI  = 8192,
  parameter int VIDX_W   = 12,
  parameter int TIDX_W   = 12,
  parameter int VTX_W    = 108,
  parameter int TRANS_W  = 384,
  parameter int DESC_LAT = 3,
  localparam int IW      = $clog2(MAX_INST),
  localparam int VA_W    = $clog2(MAX_VERT),
  localparam int TA_W    = $clog2(MAX_TRI)
) (
  input  logic                  clk,
  input  logic                  rst_render,
  input  logic                  frame_start,
  input  logic                  abort,
  input  logic [IW:0]           inst_count,
  output logic [IW-1:0]         inst_id_rd,
  input  logic [TRANS_W-1:0]    transform_in,
  input  logic [VA_W-1:0]       vbase_in,
  input  logic [VIDX_W-1:0]     vcount_in,
  input  logic [TA_W-1:0]       tbase_in,
  input  logic [TIDX_W-1:0]     tcount_in,
  output logic [TA_W-1:0]       tri_addr_rd,
  input  logic [3*VIDX_W-1:0]   idx_tri_in,
  output logic [VA_W-1:0]       vert_addr_rd,
  input  logic [VTX_W-1:0]      vert_in,
  raster_frame_sched_if.master  tri_o,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  idx_err
);
  localparam int DW = $clog2(DESC_LAT + 1);
  typedef enum logic [3:0] {IDLE, INST, DESC_WAIT, TRI_RD, TRI_WAIT, TRI_CAP, V_RD, V_WAIT, V_CAP, EMIT, NEXT, DONE} state_t;
  state_t             state_q, state_d;
  logic [IW:0]        inst_ctr_q, inst_ctr_d, inst_cnt_q, inst_cnt_d, inst_nxt;
  logic [IW-1:0]      inst_id_q, inst_id_d;
  logic [DW-1:0]      dw_q, dw_d;
  logic [TRANS_W-1:0] transform_q, transform_d;
  logic [VA_W-1:0]    vbase_q, vbase_d, vert_addr_q, vert_addr_d;
  logic [VIDX_W-1:0]  vcount_q, vcount_d, idx0_q, idx0_d, idx1_q, idx1_d, idx2_q, idx2_d, i0, i1, i2, vidx;
  logic [TA_W-1:0]    tbase_q, tbase_d, tri_addr_q, tri_addr_d;
  logic [TIDX_W-1:0]  tcount_q, tcount_d, tri_ctr_q, tri_ctr_d, tri_nxt;
  logic [1:0]         vk_q, vk_d;
  logic [VTX_W-1:0]   v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
  logic               idx_err_q, idx_err_d, last_tri;
  assign i0       = idx_tri_in[3*VIDX_W-1 -: VIDX_W];
  assign i1       = idx_tri_in[2*VIDX_W-1 -: VIDX_W];
  assign i2       = idx_tri_in[VIDX_W-1:0];
  assign vidx     = vk_q == 2'd0 ? idx0_q : vk_q == 2'd1 ? idx1_q : idx2_q;
  assign inst_nxt = inst_ctr_q + (IW+1)'(1);
  assign tri_nxt  = tri_ctr_q + TIDX_W'(1);
  assign last_tri = tri_ctr_q == tcount_q - TIDX_W'(1);
  // Next-state and datapath capture; abort overrides whatever the walk wanted to do
  always_comb begin
    state_d     = state_q;
    inst_ctr_d  = inst_ctr_q;
    inst_cnt_d  = inst_cnt_q;
    inst_id_d   = inst_id_q;
    dw_d        = dw_q;
    transform_d = transform_q;
    vbase_d     = vbase_q;
    vcount_d    = vcount_q;
    tbase_d     = tbase_q;
    tcount_d    = tcount_q;
    tri_addr_d  = tri_addr_q;
    vert_addr_d = vert_addr_q;
    tri_ctr_d   = tri_ctr_q;
    idx0_d      = idx0_q;
    idx1_d      = idx1_q;
    idx2_d      = idx2_q;
    vk_d        = vk_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    idx_err_d   = idx_err_q;
    case (state_q)
      IDLE: if (frame_start) begin
        inst_ctr_d = '0;
        inst_cnt_d = inst_count;
        idx_err_d  = 1'b0;
        state_d    = inst_count == '0 ? NEXT : INST;
      end
      INST: begin
        inst_id_d = inst_ctr_q[IW-1:0];
        dw_d      = '0;
        state_d   = DESC_WAIT;
      end
      DESC_WAIT: if (dw_q == DW'(DESC_LAT - 1)) begin
        transform_d = transform_in;
        vbase_d     = vbase_in;
        vcount_d    = vcount_in;
        tbase_d     = tbase_in;
        tcount_d    = tcount_in;
        tri_ctr_d   = '0;
        state_d     = (tcount_in == '0 || vcount_in == '0) ? NEXT : TRI_RD;
      end else dw_d = dw_q + DW'(1);
      TRI_RD: begin
        tri_addr_d = tbase_q + TA_W'(tri_ctr_q);
        state_d    = TRI_WAIT;
      end
      TRI_WAIT: state_d = TRI_CAP;
      TRI_CAP: begin
        idx0_d = i0;
        idx1_d = i1;
        idx2_d = i2;
        vk_d   = 2'd0;
        if (i0 >= vcount_q || i1 >= vcount_q || i2 >= vcount_q) begin
          idx_err_d = 1'b1;
          tri_ctr_d = tri_nxt;
          state_d   = last_tri ? NEXT : TRI_RD;
        end else state_d = V_RD;
      end
      V_RD: begin
        vert_addr_d = vbase_q + VA_W'(vidx);
        state_d     = V_WAIT;
      end
      V_WAIT: state_d = V_CAP;
      V_CAP: begin
        v0_d    = vk_q == 2'd0 ? vert_in : v0_q;
        v1_d    = vk_q == 2'd1 ? vert_in : v1_q;
        v2_d    = vk_q == 2'd2 ? vert_in : v2_q;
        vk_d    = vk_q + 2'd1;
        state_d = vk_q == 2'd2 ? EMIT : V_RD;
      end
      EMIT: if (tri_o.tri_ready) begin
        tri_ctr_d = tri_nxt;
        state_d   = last_tri ? NEXT : TRI_RD;
      end
      NEXT: begin
        inst_ctr_d = inst_nxt;
        state_d    = inst_nxt >= inst_cnt_q ? DONE : INST;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end
  // State and captured-data registers
  always_ff @(posedge clk) begin
    if (rst_render) begin
      state_q     <= IDLE;
      inst_ctr_q  <= '0;
      inst_cnt_q  <= '0;
      inst_id_q   <= '0;
      dw_q        <= '0;
      transform_q <= '0;
      vbase_q     <= '0;
      vcount_q    <= '0;
      tbase_q     <= '0;
      tcount_q    <= '0;
      tri_addr_q  <= '0;
      vert_addr_q <= '0;
      tri_ctr_q   <= '0;
      idx0_q      <= '0;
      idx1_q      <= '0;
      idx2_q      <= '0;
      vk_q        <= '0;
      v0_q        <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      idx_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_ctr_q  <= inst_ctr_d;
      inst_cnt_q  <= inst_cnt_d;
      inst_id_q   <= inst_id_d;
      dw_q        <= dw_d;
      transform_q <= transform_d;
      vbase_q     <= vbase_d;
      vcount_q    <= vcount_d;
      tbase_q     <= tbase_d;
      tcount_q    <= tcount_d;
      tri_addr_q  <= tri_addr_d;
      vert_addr_q <= vert_addr_d;
      tri_ctr_q   <= tri_ctr_d;
      idx0_q      <= idx0_d;
      idx1_q      <= idx1_d;
      idx2_q      <= idx2_d;
      vk_q        <= vk_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      idx_err_q   <= idx_err_d;
    end
  end
  assign inst_id_rd          = inst_id_q;
  assign tri_addr_rd         = tri_addr_q;
  assign vert_addr_rd        = vert_addr_q;
  assign tri_o.tri_valid     = state_q == EMIT;
  assign tri_o.v0            = v0_q;
  assign tri_o.v1            = v1_q;
  assign tri_o.v2            = v2_q;
  assign tri_o.tri_transform = transform_q;
  assign tri_o.tri_inst      = inst_ctr_q[IW-1:0];
  assign busy                = state_q != IDLE;
  assign frame_done          = state_q == DONE;
  assign idx_err             = idx_err_q;
endmodule

// File: tb/tb_raster_frame_sched.sv
// tb_raster_frame_sched: table-driven frames plus hand sequences for stall, wrap, abort and reset
module tb_raster_frame_sched;
  logic clk = 1'b0, rst_render = 1'b1, frame_start = 1'b0, abort = 1'b0;
  logic [8:0] inst_count = '0;
  logic [7:0] inst_id_rd, d1 = '0, d2 = '0;
  logic [383:0] transform_in;
  logic [12:0] vbase_in, tbase_in, tri_addr_rd, vert_addr_rd;
  logic [11:0] vcount_in, tcount_in;
  logic [35:0] idx_tri_in;
  logic [107:0] vert_in;
  logic busy, frame_done, idx_err;
  logic [35:0] tmem [8192];
  logic [12:0] cvb [4], ctb [4];
  logic [11:0] cvc [4], ctc [4];
  logic [107:0] g0 [$], g1 [$], g2 [$];
  logic [7:0] gi [$];
  logic [383:0] gt [$];
  int n_tests = 0, n_fail = 0, done_cnt = 0, cyc, dc;
  logic [107:0] s0, s1, s2;
  logic [383:0] st;
  logic stable;
  typedef struct {
    int vb, vc, tb, tc;
    logic [35:0] t0;
    int ne, err, a0, a1, a2, cyc;
  } vec_t;
  vec_t vec [9];
  always #5 clk = ~clk;
  raster_frame_sched_if tif ();
  raster_frame_sched dut (
    .clk(clk), .rst_render(rst_render), .frame_start(frame_start), .abort(abort),
    .inst_count(inst_count), .inst_id_rd(inst_id_rd), .transform_in(transform_in),
    .vbase_in(vbase_in), .vcount_in(vcount_in), .tbase_in(tbase_in), .tcount_in(tcount_in),
    .tri_addr_rd(tri_addr_rd), .idx_tri_in(idx_tri_in), .vert_addr_rd(vert_addr_rd),
    .vert_in(vert_in), .tri_o(tif), .busy(busy), .frame_done(frame_done), .idx_err(idx_err)
  );
  function automatic logic [107:0] vf(input logic [12:0] a);
    return {4'h5, {8{a}}};
  endfunction
  function automatic logic [383:0] tf(input logic [7:0] i);
    return {12{24'hC0FFEE, i}};
  endfunction
  function automatic logic [35:0] pk(input int a, input int b, input int c);
    return {12'(a), 12'(b), 12'(c)};
  endfunction
  // Memory model: descriptors valid 3 edges after inst_id_rd, triangle/vertex data one WAIT later
  always @(posedge clk) begin
    d1 <= inst_id_rd;
    d2 <= d1;
    idx_tri_in <= tmem[tri_addr_rd];
    vert_in <= vf(vert_addr_rd);
  end
  assign transform_in = tf(d2);
  assign vbase_in = cvb[d2[1:0]];
  assign vcount_in = cvc[d2[1:0]];
  assign tbase_in = ctb[d2[1:0]];
  assign tcount_in = ctc[d2[1:0]];
  // Record every accepted triangle and every frame_done pulse
  always @(negedge clk) begin
    if (tif.tri_valid && tif.tri_ready) begin
      g0.push_back(tif.v0);
      g1.push_back(tif.v1);
      g2.push_back(tif.v2);
      gi.push_back(tif.tri_inst);
      gt.push_back(tif.tri_transform);
    end
    if (frame_done) done_cnt <= done_cnt + 1;
  end
  task automatic chk(input string nm, input logic [383:0] got, input logic [383:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic cfg(input int k, input int vb, input int vc, input int tb, input int tc);
    cvb[k] = 13'(vb);
    cvc[k] = 12'(vc);
    ctb[k] = 13'(tb);
    ctc[k] = 12'(tc);
  endtask
  task automatic clr();
    g0.delete(); g1.delete(); g2.delete(); gi.delete(); gt.delete();
  endtask
  task automatic start(input int n);
    @(negedge clk);
    inst_count = 9'(n);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask
  task automatic wait_done(output int c);
    c = 0;
    while (!frame_done && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (!frame_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_done timeout: got 0 expected 1");
    end
  endtask
  task automatic wait_valid();
    int k = 0;
    while (!tif.tri_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!tif.tri_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL tri_valid timeout: got 0 expected 1");
    end
  endtask
  task automatic run_frame(input int n, output int c);
    start(n);
    wait_done(c);
    @(negedge clk);
  endtask
  initial begin
    tif.tri_ready = 1'b1;
    for (int a = 0; a < 8192; a++) tmem[a] = '0;
    for (int k = 0; k < 4; k++) cfg(k, 0, 0, 0, 0);
    vec[0] = '{100, 3, 50, 1, pk(0, 1, 2), 1, 0, 100, 101, 102, 18};
    vec[1] = '{200, 8, 10, 1, pk(7, 0, 5), 1, 0, 207, 200, 205, 18};
    vec[2] = '{8190, 5, 20, 1, pk(1, 2, 3), 1, 0, 8191, 0, 1, 18};
    vec[3] = '{300, 4, 30, 1, pk(1, 4, 2), 0, 1, 0, 0, 0, 8};
    vec[4] = '{300, 0, 31, 1, pk(0, 0, 0), 0, 0, 0, 0, 0, 5};
    vec[5] = '{300, 4, 32, 0, pk(0, 0, 0), 0, 0, 0, 0, 0, 5};
    vec[6] = '{0, 10, 33, 1, pk(9, 9, 10), 0, 1, 0, 0, 0, 8};
    vec[7] = '{0, 10, 34, 1, pk(9, 9, 9), 1, 0, 9, 9, 9, 18};
    vec[8] = '{500, 4095, 35, 1, pk(4094, 0, 4094), 1, 0, 4594, 500, 4594, 18};
    repeat (3) @(negedge clk);
    chk("reset tri_valid", tif.tri_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset idx_err", idx_err, 0);
    chk("reset addrs", {inst_id_rd, tri_addr_rd, vert_addr_rd}, 0);
    rst_render = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cfg(0, vec[i].vb, vec[i].vc, vec[i].tb, vec[i].tc);
      tmem[vec[i].tb] = vec[i].t0;
      clr();
      run_frame(1, cyc);
      chk($sformatf("v%0d cycles", i), cyc, vec[i].cyc);
      chk($sformatf("v%0d emits", i), g0.size(), vec[i].ne);
      chk($sformatf("v%0d idx_err", i), idx_err, vec[i].err);
      chk($sformatf("v%0d busy", i), busy, 0);
      if (vec[i].ne > 0 && g0.size() > 0) begin
        chk($sformatf("v%0d v0", i), g0[0], vf(13'(vec[i].a0)));
        chk($sformatf("v%0d v1", i), g1[0], vf(13'(vec[i].a1)));
        chk($sformatf("v%0d v2", i), g2[0], vf(13'(vec[i].a2)));
        chk($sformatf("v%0d inst", i), gi[0], 0);
        chk($sformatf("v%0d transform", i), gt[0], tf(8'd0));
        chk($sformatf("v%0d tri_addr", i), tri_addr_rd, vec[i].tb);
        chk($sformatf("v%0d vert_addr", i), vert_addr_rd, vec[i].a2);
      end
    end
    cfg(0, 1000, 4, 300, 2);
    cfg(1, 0, 4, 0, 0);
    cfg(2, 2000, 4, 400, 1);
    tmem[300] = pk(0, 1, 2);
    tmem[301] = pk(3, 2, 1);
    tmem[400] = pk(2, 2, 0);
    clr();
    run_frame(3, cyc);
    chk("multi emits", g0.size(), 3);
    if (g0.size() == 3) begin
      chk("multi t0 v0", g0[0], vf(13'd1000));
      chk("multi t1 v0", g0[1], vf(13'd1003));
      chk("multi t2 v0", g0[2], vf(13'd2002));
      chk("multi t2 v2", g2[2], vf(13'd2000));
      chk("multi insts", {gi[0], gi[1], gi[2]}, {8'd0, 8'd0, 8'd2});
      chk("multi t2 transform", gt[2], tf(8'd2));
    end
    cfg(0, 60, 3, 60, 1);
    tmem[60] = pk(2, 1, 0);
    clr();
    tif.tri_ready = 1'b0;
    start(1);
    wait_valid();
    s0 = tif.v0; s1 = tif.v1; s2 = tif.v2; st = tif.tri_transform;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!tif.tri_valid || tif.v0 !== s0 || tif.v1 !== s1 || tif.v2 !== s2 || tif.tri_transform !== st) stable = 1'b0;
    end
    chk("stall stable", stable, 1);
    chk("stall v0", s0, vf(13'd62));
    chk("stall v2", s2, vf(13'd60));
    @(posedge clk);
    #1 tif.tri_ready = 1'b1;
    wait_done(cyc);
    @(negedge clk);
    chk("stall transfers", g0.size(), 1);
    cfg(0, 40, 4, 500, 2);
    tmem[500] = pk(1, 4, 2);
    tmem[501] = pk(3, 0, 1);
    clr();
    run_frame(1, cyc);
    chk("err idx_err", idx_err, 1);
    chk("err emits", g0.size(), 1);
    if (g0.size() == 1) begin
      chk("err next v0", g0[0], vf(13'd43));
      chk("err next v2", g2[0], vf(13'd41));
    end
    clr();
    run_frame(0, cyc);
    chk("count0 within 3", cyc <= 3, 1);
    chk("count0 emits", g0.size(), 0);
    chk("count0 clears idx_err", idx_err, 0);
    cfg(0, 0, 4, 8190, 4);
    tmem[8190] = pk(0, 0, 0);
    tmem[8191] = pk(1, 1, 1);
    tmem[0] = pk(2, 2, 2);
    tmem[1] = pk(3, 3, 3);
    clr();
    run_frame(1, cyc);
    chk("wrap emits", g0.size(), 4);
    if (g0.size() == 4) chk("wrap order", {g0[0], g0[1], g0[2], g0[3]}, {vf(13'd0), vf(13'd1), vf(13'd2), vf(13'd3)});
    chk("wrap last tri_addr", tri_addr_rd, 1);
    cfg(0, 100, 3, 50, 1);
    clr();
    tif.tri_ready = 1'b0;
    dc = done_cnt;
    start(1);
    wait_valid();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort tri_valid", tif.tri_valid, 0);
    chk("abort busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("abort no frame_done", done_cnt, dc);
    start(1);
    wait_valid();
    rst_render = 1'b1;
    @(negedge clk);
    rst_render = 1'b0;
    chk("reset mid tri_valid", tif.tri_valid, 0);
    chk("reset mid busy", busy, 0);
    chk("reset mid addrs", {tri_addr_rd, vert_addr_rd}, 0);
    repeat (20) @(negedge clk);
    chk("reset mid no frame_done", done_cnt, dc);
    tif.tri_ready = 1'b1;
    clr();
    run_frame(1, cyc);
    chk("recover emits", g0.size(), 1);
    if (g0.size() == 1) chk("recover v1", g1[0], vf(13'd101));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
